// File: rtl/inst_legality_monitor_if.sv
// Bus bundle for the instruction legality monitor: beat inputs plus registered verdicts.
interface inst_legality_monitor_if #(
  parameter int NUM_LANES = 1,
  parameter int CNT_W     = 16
);
  logic                      clear;
  logic [2:0]                mode;
  logic                      in_valid;
  logic [32*NUM_LANES-1:0]   instruction;
  logic                      out_valid;
  logic [NUM_LANES-1:0]      out_legal;
  logic                      viol_sticky;
  logic [NUM_LANES-1:0]      viol_lanes;
  logic [31:0]               viol_inst;
  logic [CNT_W-1:0]          legal_count;
  logic                      nop_run_exceeded;

  modport master (
    output clear, mode, in_valid, instruction,
    input  out_valid, out_legal, viol_sticky, viol_lanes, viol_inst,
           legal_count, nop_run_exceeded
  );

  modport slave (
    input  clear, mode, in_valid, instruction,
    output out_valid, out_legal, viol_sticky, viol_lanes, viol_inst,
           legal_count, nop_run_exceeded
  );
endinterface

// File: rtl/inst_legality_monitor.sv
// Registered RV64G-subset legality checker: per-lane verdicts, sticky violation
// capture, saturating legal-lane counter and a bound on consecutive NOP beats.

// Combinational legality decode for one 32-bit instruction slot.
module inst_legality_lane #(
  parameter int REG_LIMIT = 16
) (
  input  logic [31:0] inst,
  input  logic [2:0]  mode,
  output logic        legal,
  output logic        is_nop
);
  localparam logic [5:0] RLIM = 6'(REG_LIMIT);

  logic [6:0] opcode, funct7, f7_base;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       rd_ok, rs1_ok, rs2_ok, fp_prec_ok;

  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign funct7  = inst[31:25];
  // funct7[0] selects double precision; the base encoding is shared.
  assign f7_base = {funct7[6:1], 1'b0};

  assign rd_ok      = {1'b0, rd}  < RLIM;
  assign rs1_ok     = {1'b0, rs1} < RLIM;
  assign rs2_ok     = {1'b0, rs2} < RLIM;
  assign fp_prec_ok = funct7[0] ? mode[2] : mode[1];

  assign is_nop = (opcode == 7'b1111111) && (inst[31:7] == 25'd0);

  // Opcode-directed legality decode; anything unlisted is illegal.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      7'b0110011: legal = rd_ok && rs1_ok && rs2_ok &&
                          ((funct7 == 7'b0000000) ||
                           (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                           (funct7 == 7'b0000001 && funct3 <= 3'b011 && mode[0]));
      7'b0010011: begin
        if (rd_ok && rs1_ok) begin
          case (funct3)
            3'b001:  legal = (inst[31:26] == 6'b000000);
            3'b101:  legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
            default: legal = 1'b1;
          endcase
        end
      end
      7'b0000011: legal = (funct3 == 3'b010) && (rs1 == 5'd0) && (funct7 == 7'd0) && rd_ok;
      7'b0100011: legal = (funct3 == 3'b010) && (rs1 == 5'd0) && (funct7 == 7'd0) && rs2_ok;
      7'b0000111: legal = ((funct3 == 3'b010 && mode[1]) || (funct3 == 3'b011 && mode[2])) &&
                          (rs1 == 5'd0) && (funct7 == 7'd0) && rd_ok;
      7'b0100111: legal = ((funct3 == 3'b010 && mode[1]) || (funct3 == 3'b011 && mode[2])) &&
                          (rs1 == 5'd0) && (funct7 == 7'd0) && rs2_ok;
      7'b1010011: begin
        if (rd_ok && rs1_ok && rs2_ok && funct3 <= 3'b100 && fp_prec_ok) begin
          case (f7_base)
            7'b0000000, 7'b0000100,
            7'b0001000, 7'b0001100: legal = 1'b1;
            7'b0101100:             legal = (rs2 == 5'd0);
            7'b0010100:             legal = (funct3 <= 3'b001);
            7'b1010000:             legal = (funct3 <= 3'b010);
            default:                legal = 1'b0;
          endcase
        end
      end
      7'b1111111: legal = is_nop;
      default:    legal = 1'b0;
    endcase
  end
endmodule

module inst_legality_monitor #(
  parameter int NUM_LANES   = 1,
  parameter int REG_LIMIT   = 16,
  parameter int MAX_NOP_RUN = 4,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst,
  inst_legality_monitor_if.slave bus
);
  localparam int PW  = $clog2(NUM_LANES + 1);
  localparam int SW  = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam int NRW = $clog2(MAX_NOP_RUN + 2);
  localparam logic [NRW-1:0] NOP_MAX = NRW'(MAX_NOP_RUN);

  logic [NUM_LANES-1:0] lane_legal, lane_nop, legal_v, illegal_v;
  logic [PW-1:0]        pop;
  logic [SW-1:0]        sum;
  logic [31:0]          first_ill;

  logic                 out_valid_q, out_valid_d;
  logic [NUM_LANES-1:0] out_legal_q, out_legal_d;
  logic                 viol_sticky_q, viol_sticky_d;
  logic [NUM_LANES-1:0] viol_lanes_q, viol_lanes_d;
  logic [31:0]          viol_inst_q, viol_inst_d;
  logic [CNT_W-1:0]     legal_count_q, legal_count_d;
  logic [NRW-1:0]       nop_run_q, nop_run_d;
  logic                 nop_exc_q, nop_exc_d;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    inst_legality_lane #(.REG_LIMIT(REG_LIMIT)) u_lane (
      .inst   (bus.instruction[32*g +: 32]),
      .mode   (bus.mode),
      .legal  (lane_legal[g]),
      .is_nop (lane_nop[g])
    );
  end

  assign legal_v   = bus.in_valid ? lane_legal  : '0;
  assign illegal_v = bus.in_valid ? ~lane_legal : '0;

  // Beat summary: legal popcount and the lowest-index illegal instruction.
  always_comb begin
    pop       = '0;
    first_ill = '0;
    for (int i = 0; i < NUM_LANES; i++) pop = pop + PW'(legal_v[i]);
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (illegal_v[i]) first_ill = bus.instruction[32*i +: 32];
    sum = SW'(legal_count_q) + SW'(pop);
  end

  // Next-state for verdicts, sticky capture, counter and NOP-run tracking.
  always_comb begin
    out_valid_d   = bus.in_valid;
    out_legal_d   = legal_v;
    viol_sticky_d = viol_sticky_q;
    viol_lanes_d  = viol_lanes_q;
    viol_inst_d   = viol_inst_q;
    legal_count_d = legal_count_q;
    nop_run_d     = nop_run_q;
    nop_exc_d     = nop_exc_q;
    if (bus.in_valid) begin
      legal_count_d = (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      viol_lanes_d  = viol_lanes_q | illegal_v;
      if (|illegal_v) begin
        viol_sticky_d = 1'b1;
        if (!viol_sticky_q) viol_inst_d = first_ill;
      end
      if (&lane_nop) begin
        // Run saturates one past the bound; reaching that point flags it.
        if (nop_run_q <= NOP_MAX) nop_run_d = nop_run_q + NRW'(1);
        if (nop_run_q >= NOP_MAX) nop_exc_d = 1'b1;
      end else begin
        nop_run_d = '0;
      end
    end
    if (bus.clear) begin
      viol_sticky_d = 1'b0;
      viol_lanes_d  = '0;
      viol_inst_d   = '0;
      legal_count_d = '0;
      nop_run_d     = '0;
      nop_exc_d     = 1'b0;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_legal_q   <= '0;
      viol_sticky_q <= 1'b0;
      viol_lanes_q  <= '0;
      viol_inst_q   <= '0;
      legal_count_q <= '0;
      nop_run_q     <= '0;
      nop_exc_q     <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_legal_q   <= out_legal_d;
      viol_sticky_q <= viol_sticky_d;
      viol_lanes_q  <= viol_lanes_d;
      viol_inst_q   <= viol_inst_d;
      legal_count_q <= legal_count_d;
      nop_run_q     <= nop_run_d;
      nop_exc_q     <= nop_exc_d;
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.out_legal        = out_legal_q;
  assign bus.viol_sticky      = viol_sticky_q;
  assign bus.viol_lanes       = viol_lanes_q;
  assign bus.viol_inst        = viol_inst_q;
  assign bus.legal_count      = legal_count_q;
  assign bus.nop_run_exceeded = nop_exc_q;
endmodule

// File: tb/tb_inst_legality_monitor.sv
// Directed bench for inst_legality_monitor: single-lane decode table, NOP-run
// bound, two-lane sticky capture with clear, and counter saturation / async reset.
module tb_inst_legality_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_legality_monitor_if #(.NUM_LANES(1), .CNT_W(16)) if1 ();
  inst_legality_monitor_if #(.NUM_LANES(2), .CNT_W(16)) if2 ();
  inst_legality_monitor_if #(.NUM_LANES(1), .CNT_W(2))  if3 ();

  inst_legality_monitor #(.NUM_LANES(1), .REG_LIMIT(16), .MAX_NOP_RUN(4), .CNT_W(16))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  inst_legality_monitor #(.NUM_LANES(2), .REG_LIMIT(16), .MAX_NOP_RUN(4), .CNT_W(16))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  inst_legality_monitor #(.NUM_LANES(1), .REG_LIMIT(16), .MAX_NOP_RUN(4), .CNT_W(2))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] inst;
    logic        legal;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] ADD17 = 32'h003108B3;
  localparam logic [31:0] LWBAD = 32'h0000A083;
  localparam logic [31:0] NOP   = 32'h0000007F;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the selected DUT (others idle), sample 1 time unit after the edge.
  task automatic beat(input int d, input logic [2:0] m, input logic [63:0] ins,
                      input logic v, input logic clr);
    @(negedge clk);
    if1.in_valid = 1'b0; if1.clear = 1'b0;
    if2.in_valid = 1'b0; if2.clear = 1'b0;
    if3.in_valid = 1'b0; if3.clear = 1'b0;
    case (d)
      1: begin if1.mode = m; if1.instruction = ins[31:0]; if1.in_valid = v; if1.clear = clr; end
      2: begin if2.mode = m; if2.instruction = ins;       if2.in_valid = v; if2.clear = clr; end
      default: begin if3.mode = m; if3.instruction = ins[31:0]; if3.in_valid = v; if3.clear = clr; end
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    if1.clear = 0; if1.mode = 0; if1.in_valid = 0; if1.instruction = '0;
    if2.clear = 0; if2.mode = 0; if2.in_valid = 0; if2.instruction = '0;
    if3.clear = 0; if3.mode = 0; if3.in_valid = 0; if3.instruction = '0;

    vecs.push_back('{3'b000, ADD,           1'b1});
    vecs.push_back('{3'b000, ADD17,         1'b0});
    vecs.push_back('{3'b000, 32'h023100B3,  1'b0}); // MUL, M off
    vecs.push_back('{3'b001, 32'h023100B3,  1'b1}); // MUL, M on
    vecs.push_back('{3'b000, 32'h00002083,  1'b1}); // LW rs1=0
    vecs.push_back('{3'b000, LWBAD,         1'b0}); // LW rs1=1
    vecs.push_back('{3'b000, 32'h003100D3,  1'b0}); // FADD.S, F off
    vecs.push_back('{3'b010, 32'h003100D3,  1'b1}); // FADD.S, F on
    vecs.push_back('{3'b100, 32'h003100D3,  1'b0}); // FADD.S, only D on
    vecs.push_back('{3'b100, 32'h023100D3,  1'b1}); // FADD.D, D on
    vecs.push_back('{3'b000, NOP,           1'b1});
    vecs.push_back('{3'b000, 32'h0000017F,  1'b0}); // NOP opcode with rd!=0
    vecs.push_back('{3'b000, 32'h40315093,  1'b1}); // SRAI
    vecs.push_back('{3'b000, 32'h04015093,  1'b0}); // shift with inst[31:26]=000001
    vecs.push_back('{3'b000, 32'h403100B3,  1'b1}); // SUB
    vecs.push_back('{3'b000, 32'h403110B3,  1'b0}); // funct7=0100000 funct3=001
    vecs.push_back('{3'b000, 32'h010100B3,  1'b0}); // rs2=16
    vecs.push_back('{3'b000, 32'h00F100B3,  1'b1}); // rs2=15
    vecs.push_back('{3'b010, 32'h00002087,  1'b1}); // FLW, F on
    vecs.push_back('{3'b000, 32'h00002087,  1'b0}); // FLW, F off

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(if1.out_valid), 64'd0);
    chk("reset_viol_sticky", 64'(if1.viol_sticky), 64'd0);
    chk("reset_legal_count", 64'(if1.legal_count), 64'd0);
    chk("reset_viol_inst", 64'(if1.viol_inst), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD then rd=17
    beat(1, 3'b000, 64'(ADD), 1'b1, 1'b0);
    chk("add_valid", 64'(if1.out_valid), 64'd1);
    chk("add_legal", 64'(if1.out_legal), 64'd1);
    chk("add_sticky", 64'(if1.viol_sticky), 64'd0);
    beat(1, 3'b000, 64'(ADD17), 1'b1, 1'b0);
    chk("rd17_legal", 64'(if1.out_legal), 64'd0);
    chk("rd17_viol_inst", 64'(if1.viol_inst), 64'(ADD17));
    chk("rd17_count", 64'(if1.legal_count), 64'd1);
    chk("rd17_sticky", 64'(if1.viol_sticky), 64'd1);
    chk("rd17_lanes", 64'(if1.viol_lanes), 64'd1);

    // Decode table
    foreach (vecs[i]) begin
      beat(1, vecs[i].mode, 64'(vecs[i].inst), 1'b1, 1'b0);
      chk($sformatf("vec%0d_legal", i), 64'(if1.out_legal), 64'(vecs[i].legal));
      chk($sformatf("vec%0d_valid", i), 64'(if1.out_valid), 64'd1);
    end
    chk("viol_inst_held", 64'(if1.viol_inst), 64'(ADD17));
    beat(1, 3'b000, 64'(ADD), 1'b0, 1'b0);
    chk("idle_valid", 64'(if1.out_valid), 64'd0);
    chk("idle_legal", 64'(if1.out_legal), 64'd0);

    // NOP run bound with an idle gap between beats 2 and 3
    beat(1, 3'b000, 64'd0, 1'b0, 1'b1);
    chk("clear_sticky", 64'(if1.viol_sticky), 64'd0);
    chk("clear_count", 64'(if1.legal_count), 64'd0);
    beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    beat(1, 3'b000, 64'(NOP), 1'b0, 1'b0);
    beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    chk("nop4_not_exceeded", 64'(if1.nop_run_exceeded), 64'd0);
    beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    chk("nop5_exceeded", 64'(if1.nop_run_exceeded), 64'd1);
    beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    chk("nop6_still_exceeded", 64'(if1.nop_run_exceeded), 64'd1);

    // Non-NOP restarts the run
    beat(1, 3'b000, 64'd0, 1'b0, 1'b1);
    chk("clear_nop_exc", 64'(if1.nop_run_exceeded), 64'd0);
    for (int k = 0; k < 3; k++) beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    beat(1, 3'b000, 64'(ADD), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    chk("restart_nop4", 64'(if1.nop_run_exceeded), 64'd0);
    beat(1, 3'b000, 64'(NOP), 1'b1, 1'b0);
    chk("restart_nop5", 64'(if1.nop_run_exceeded), 64'd1);

    // Two lanes, both illegal
    beat(2, 3'b000, {ADD17, LWBAD}, 1'b1, 1'b0);
    chk("l2_legal", 64'(if2.out_legal), 64'd0);
    chk("l2_viol_lanes", 64'(if2.viol_lanes), 64'd3);
    chk("l2_viol_inst", 64'(if2.viol_inst), 64'(LWBAD));
    beat(2, 3'b000, {ADD, ADD}, 1'b1, 1'b1);
    chk("l2_clear_legal", 64'(if2.out_legal), 64'd3);
    chk("l2_clear_valid", 64'(if2.out_valid), 64'd1);
    chk("l2_clear_lanes", 64'(if2.viol_lanes), 64'd0);
    chk("l2_clear_sticky", 64'(if2.viol_sticky), 64'd0);
    chk("l2_clear_inst", 64'(if2.viol_inst), 64'd0);
    chk("l2_clear_count", 64'(if2.legal_count), 64'd0);
    beat(2, 3'b000, {ADD17, ADD}, 1'b1, 1'b0);
    chk("l2_hi_lanes", 64'(if2.viol_lanes), 64'd2);
    chk("l2_hi_inst", 64'(if2.viol_inst), 64'(ADD17));
    chk("l2_hi_count", 64'(if2.legal_count), 64'd1);

    // Saturating counter, CNT_W=2
    for (int k = 0; k < 4; k++) begin
      beat(3, 3'b000, 64'(ADD), 1'b1, 1'b0);
      chk($sformatf("sat_count%0d", k), 64'(if3.legal_count), 64'((k < 3) ? k + 1 : 3));
    end

    // Async reset mid-stream
    @(negedge clk);
    if3.in_valid = 1'b1; if3.instruction = ADD17;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(if3.out_valid), 64'd0);
    chk("arst_count", 64'(if3.legal_count), 64'd0);
    chk("arst_sticky", 64'(if3.viol_sticky), 64'd0);
    chk("arst_viol_inst", 64'(if3.viol_inst), 64'd0);
    chk("arst_nop_exc", 64'(if1.nop_run_exceeded), 64'd0);
    @(negedge clk);
    if3.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(if3.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_legality_monitor.md
# inst_legality_monitor

Parametrised, registered instruction-legality checker for the SQED formal harness. It sits between the symbolic instruction source and the DUT fetch port and evaluates NUM_LANES instruction slots per beat against the RV64G subset. Per-extension legality is selectable at run time. It adds behaviour the combinational constraint lacks: registered verdicts, sticky violation capture, a legal-instruction counter and a bound on consecutive NOP (stall) beats.

## Interface
- NUM_LANES, 1: instruction slots checked per beat.
- REG_LIMIT, 16: register indices used by an instruction must be < REG_LIMIT (range 1..32).
- MAX_NOP_RUN, 4: maximum consecutive all-NOP beats before flagging.
- CNT_W, 16: width of legal_count.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of sticky flags and counters.
- mode  in  3  bit0 M-extension, bit1 F (single), bit2 D (double) enable.
- in_valid  in  1  beat present on instruction.
- instruction  in  32*NUM_LANES  lane i at bits [32i+31:32i].
- out_valid  out  1  registered in_valid.
- out_legal  out  NUM_LANES  registered per-lane verdict.
- viol_sticky  out  1  any illegal lane seen since reset/clear.
- viol_lanes  out  NUM_LANES  sticky OR of illegal lanes.
- viol_inst  out  32  first illegal instruction captured.
- legal_count  out  CNT_W  saturating count of legal lanes.
- nop_run_exceeded  out  1  sticky stall-bound violation.

## Operation
- Fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- ALU-R (0110011), rd/rs1/rs2 < REG_LIMIT: funct7=0 with any funct3; funct7=0100000 with funct3 000 or 101. funct7=0000001 with funct3 000..011 is legal only if mode[0].
- ALU-I (0010011), rd/rs1 < REG_LIMIT: funct3 000/010/011/100/110/111 with any immediate. funct3 001 needs inst[31:26]=0. funct3 101 needs inst[31:26] = 000000 or 010000.
- LW (0000011) and SW (0100011): funct3 010, rs1=0, funct7=0, plus rd<REG_LIMIT (LW) or rs2<REG_LIMIT (SW).
- NOP: opcode 1111111 and inst[31:7]=0. Always legal.
- FP arithmetic (1010011): rd/rs1/rs2 < REG_LIMIT and funct3 ≤ 100. Single precision (mode[1]) takes funct7 0000000, 0000100, 0001000, 0001100. It also takes 0101100 with rs2=0, 0010100 with funct3 000/001, and 1010000 with funct3 000/001/010. Double precision (mode[2]) uses the same set with funct7[0]=1.
- FLW/FSW (0000111/0100111, funct3 010) need mode[1]; FLD/FSD (funct3 011) need mode[2]. Same rs1/funct7/register rules as LW/SW.
- Anything else is illegal. mode is sampled in the same cycle as the instruction.
- Updates on a beat with in_valid=1:
  - legal_count += popcount(legal lanes), saturating at all-ones.
  - viol_lanes |= illegal lanes; viol_sticky set if any lane is illegal.
  - viol_inst loads the lowest-index illegal lane only while viol_sticky=0.
- NOP run: nop_run counts consecutive valid beats where every lane is NOP. It is reset by any valid beat containing a non-NOP. in_valid=0 beats neither count nor reset it. When a beat would make the run exceed MAX_NOP_RUN, nop_run_exceeded sets. The run counter saturates at MAX_NOP_RUN+1.
- clear: zeroes viol_sticky, viol_lanes, viol_inst, legal_count, nop_run and nop_run_exceeded. It overrides that cycle's updates to those registers. out_valid/out_legal still reflect that cycle's beat.

## Timing
- All outputs are registered; verdict latency is 1 cycle (beat at edge N is visible after edge N+1).
- in_valid=0: next out_valid=0 and out_legal=0.
- Reset (async assert, sync-safe deassert): all outputs are 0, including the internal run counter. Reset mid-run discards the in-flight verdict.
- No backpressure: a beat is accepted every cycle in_valid=1.
- Simultaneous illegal lanes: viol_inst takes the lowest index; viol_lanes records all of them.

## Test plan
- NUM_LANES=1, mode=0: inputs 0x003100B3 (ADD x1,x2,x3) then 0x003108B3 (rd=17). Expected: out_legal 1 then 0; viol_inst=0x003108B3; legal_count=1.
- MUL x1,x2,x3 = 0x023100B3 with mode=000, then mode=001. Expected: illegal, then legal.
- LW 0x00002083 is legal; 0x0000A083 (rs1=1) is illegal. FADD.S 0x003100D3 is legal only with mode[1]=1.
- MAX_NOP_RUN=4: five 0x0000007F beats with an idle cycle between beats 2 and 3. Expected: nop_run_exceeded rises after the fifth beat, not before. A non-NOP beat restarts the run.
- NUM_LANES=2: lanes {0x003108B3, 0x0000A083} in one beat. Expected: viol_lanes=2'b11 and viol_inst=0x0000A083 (lane 0). Asserting clear on the next beat zeroes the sticky state.
- Saturation: CNT_W=2, four legal beats. Expected: legal_count stays at 3. rst asserted mid-stream zeroes all outputs asynchronously.
